// File: rtl/ldpc_seq_pkg.sv
// Shared types for the LDPC check-node sequencer: FSM states, tag layout
// and the tag pipeline depth helper.
package ldpc_seq_pkg;

  localparam int ROW_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic                 valid;
    logic [ROW_W_DEF-1:0] addr;
  } tag_t;

  function automatic int pipe_depth(input int rd_lat, input int cnu_lat);
    return rd_lat + cnu_lat;
  endfunction

endpackage

// File: rtl/ldpc_tag_pipe.sv
// Shift register of {valid, addr} tags following rows through memory + CNU.
// MSB of each entry is the valid bit; a mid tap exposes only that bit.
module ldpc_tag_pipe #(
  parameter int DEPTH = 11,
  parameter int WIDTH = 9,
  parameter int TAP   = 1
) (
  input  logic             i_clock,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_tap_valid,
  output logic [WIDTH-1:0] o_tail
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clock) begin
    if (i_clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tap_valid = r_pipe[TAP-1][WIDTH-1];
  assign o_tail      = r_pipe[DEPTH-1];

endmodule

// File: rtl/ldpc_cnu_sequencer.sv
// Sequences one min-sign CNU over all rows of a layer for repeated iterations,
// issuing row reads and generating aligned write-back addresses.
module ldpc_cnu_sequencer
  import ldpc_seq_pkg::*;
#(
  parameter int ROW_W        = 8,
  parameter int ITER_W       = 5,
  parameter int READ_LATENCY = 1,
  parameter int CNU_LATENCY  = 10
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ROW_W-1:0]  i_num_rows,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_early_stop,
  input  logic              i_abort,
  input  logic              i_cnu_valid,
  output logic              o_rd_en,
  output logic [ROW_W-1:0]  o_rd_addr,
  output logic              o_cnu_valid,
  output logic              o_wr_en,
  output logic [ROW_W-1:0]  o_wr_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_converged,
  output logic [ITER_W-1:0] o_iter_count,
  output logic              o_sync_err
);

  localparam int PIPE  = pipe_depth(READ_LATENCY, CNU_LATENCY);
  localparam int CNT_W = $clog2(PIPE + 1);

  seq_state_e        r_state, w_next;
  logic [ROW_W-1:0]  r_rows, r_addr;
  logic [ITER_W-1:0] r_max, r_iter, w_iter_inc;
  logic              r_busy, r_done, r_conv, r_abort, r_sync;
  logic [CNT_W-1:0]  r_infl, r_mask;
  logic              w_rd_en, w_accept, w_tap_vld, w_tail_vld;
  logic [ROW_W-1:0]  w_tail_addr;

  ldpc_tag_pipe #(
    .DEPTH (PIPE),
    .WIDTH (ROW_W + 1),
    .TAP   (READ_LATENCY)
  ) u_tag_pipe (
    .i_clock     (i_clock),
    .i_clr       (i_reset),
    .i_din       ({w_rd_en, r_addr}),
    .o_tap_valid (w_tap_vld),
    .o_tail      ({w_tail_vld, w_tail_addr})
  );

  assign w_iter_inc = r_iter + 1'b1;

  always_comb begin
    w_next   = r_state;
    w_rd_en  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !r_busy) begin
          w_accept = 1'b1;
          w_next   = (i_num_rows == '0 || i_max_iter == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Abort suppresses the read of the current cycle.
        if (i_abort) begin
          w_next = S_DRAIN;
        end else begin
          w_rd_en = 1'b1;
          if (r_addr == r_rows - 1'b1) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_infl == '0) w_next = (r_abort || i_abort) ? S_DONE : S_CHECK;
      end
      S_CHECK: begin
        if (i_early_stop || w_iter_inc == r_max) w_next = S_DONE;
        else                                      w_next = S_ISSUE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_rows  <= '0;
      r_addr  <= '0;
      r_max   <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_conv  <= 1'b0;
      r_abort <= 1'b0;
      r_sync  <= 1'b0;
      r_infl  <= '0;
      r_mask  <= CNT_W'(PIPE);
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);

      if (w_accept)    r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;

      if (w_rd_en && !w_tail_vld)      r_infl <= r_infl + 1'b1;
      else if (!w_rd_en && w_tail_vld) r_infl <= r_infl - 1'b1;

      // Stale CNU contents after reset are ignored until the pipe has flushed.
      if (r_mask != '0)                    r_mask <= r_mask - 1'b1;
      else if (i_cnu_valid != w_tail_vld) r_sync <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rows  <= i_num_rows;
            r_max   <= i_max_iter;
            r_iter  <= '0;
            r_addr  <= '0;
            r_conv  <= 1'b0;
            r_abort <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (i_abort) r_abort <= 1'b1;
          r_addr <= (w_next == S_ISSUE) ? r_addr + 1'b1 : '0;
        end
        S_DRAIN: begin
          if (i_abort) r_abort <= 1'b1;
        end
        S_CHECK: begin
          r_iter <= w_iter_inc;
          if (i_early_stop) r_conv <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_en      = w_rd_en;
  assign o_rd_addr    = r_addr;
  assign o_cnu_valid  = w_tap_vld;
  assign o_wr_en      = w_tail_vld;
  assign o_wr_addr    = w_tail_addr;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_converged  = r_conv;
  assign o_iter_count = r_iter;
  assign o_sync_err   = r_sync;

endmodule

// File: tb/tb_ldpc_cnu_sequencer.sv
// Self-checking bench for ldpc_cnu_sequencer: randomized jobs checked against
// a trace-level model of reads, write-backs, iteration count and convergence.
module tb_ldpc_cnu_sequencer;

  localparam int ROW_W  = 8;
  localparam int ITER_W = 5;
  localparam int RL     = 1;
  localparam int CL     = 10;
  localparam int PIPE   = RL + CL;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_start = 1'b0;
  logic [ROW_W-1:0]  i_num_rows = '0;
  logic [ITER_W-1:0] i_max_iter = '0;
  logic              i_early_stop = 1'b0;
  logic              i_abort = 1'b0;
  logic              i_cnu_valid = 1'b0;
  logic              o_rd_en, o_cnu_valid, o_wr_en, o_busy, o_done, o_converged, o_sync_err;
  logic [ROW_W-1:0]  o_rd_addr, o_wr_addr;
  logic [ITER_W-1:0] o_iter_count;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int cnu_bad = 0;
  bit mon_en = 1'b0;
  bit glitch = 1'b0;
  bit prev_rd = 1'b0;
  logic [PIPE-1:0] hist = '0;
  int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_cyc_q[$];

  ldpc_cnu_sequencer #(
    .ROW_W(ROW_W), .ITER_W(ITER_W), .READ_LATENCY(RL), .CNU_LATENCY(CL)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .i_num_rows(i_num_rows), .i_max_iter(i_max_iter),
    .i_early_stop(i_early_stop), .i_abort(i_abort), .i_cnu_valid(i_cnu_valid),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_cnu_valid(o_cnu_valid),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_busy(o_busy), .o_done(o_done),
    .o_converged(o_converged), .o_iter_count(o_iter_count), .o_sync_err(o_sync_err)
  );

  always #5 i_clock = ~i_clock;

  // Trace logger plus a CNU stand-in: output-valid is input-valid delayed CL.
  initial begin : monitor
    forever begin
      @(negedge i_clock);
      cyc++;
      if (mon_en) begin
        if (o_rd_en) begin rd_addr_q.push_back(int'(o_rd_addr)); rd_cyc_q.push_back(cyc); end
        if (o_wr_en) begin wr_addr_q.push_back(int'(o_wr_addr)); wr_cyc_q.push_back(cyc); end
        if (o_cnu_valid !== prev_rd) cnu_bad++;
        prev_rd = o_rd_en;
      end else begin
        prev_rd = 1'b0;
      end
      hist = {hist[PIPE-2:0], o_cnu_valid};
      i_cnu_valid = hist[CL] | glitch;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    tick();
    i_reset = 1'b0;
    rd_addr_q.delete(); rd_cyc_q.delete(); wr_addr_q.delete(); wr_cyc_q.delete();
    mon_en = 1'b1;
  endtask

  // Spec-level expectation of a job trace: pass-major row order, one row per
  // cycle, each write PIPE cycles after its read, next pass after last write.
  function automatic int trace_errs(input int rows, input int nreads);
    int e = 0;
    if (rd_addr_q.size() != nreads || wr_addr_q.size() != nreads)
      return 1000 + rd_addr_q.size() * 10 + wr_addr_q.size();
    for (int i = 0; i < nreads; i++) begin
      if (rd_addr_q[i] != i % rows) e++;
      if (wr_addr_q[i] != rd_addr_q[i]) e++;
      if (wr_cyc_q[i] - rd_cyc_q[i] != PIPE) e++;
      if (i % rows != 0 && rd_cyc_q[i] != rd_cyc_q[i-1] + 1) e++;
      if (i % rows == 0 && i > 0 && rd_cyc_q[i] <= wr_cyc_q[i-1]) e++;
    end
    return e;
  endfunction

  task automatic run_job(input int rows, input int iters, input bit es,
                         input int abort_k, input int extra_k,
                         output int lat, output bit busy_ok, output int got_iter,
                         output bit got_conv, output bit post_busy, output int held_iter);
    rd_addr_q.delete(); rd_cyc_q.delete(); wr_addr_q.delete(); wr_cyc_q.delete();
    cnu_bad      = 0;
    i_num_rows   = ROW_W'(rows);
    i_max_iter   = ITER_W'(iters);
    i_early_stop = es;
    i_start      = 1'b1;
    lat = -1; busy_ok = 1'b1; got_iter = -1; got_conv = 1'b0; post_busy = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      i_start = 1'b0;
      if (o_done) begin
        lat = k; got_iter = int'(o_iter_count); got_conv = o_converged;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
      i_abort = (k == abort_k);
      if (k == extra_k) begin i_start = 1'b1; i_num_rows = ROW_W'(3); end
    end
    i_abort = 1'b0;
    // Start during the done cycle must be ignored.
    i_start = 1'b1;
    i_num_rows = ROW_W'(5);
    i_max_iter = ITER_W'(1);
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      post_busy |= o_busy;
      tick();
    end
    held_iter = int'(o_iter_count);
    i_early_stop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({o_rd_en, o_rd_addr, o_cnu_valid, o_wr_en, o_wr_addr, o_busy, o_done,
         o_converged, o_iter_count, o_sync_err} !== '0)
      $display("FAIL reset_outputs: got rd=%0b busy=%0b done=%0b iter=%0d sync=%0b want all 0",
               o_rd_en, o_busy, o_done, o_iter_count, o_sync_err);
    else passed++;
    repeat (3) tick();
    total++;
    if ({o_busy, o_rd_en, o_sync_err} !== 3'b000)
      $display("FAIL reset_idle: got busy/rd/sync=%b want 000", {o_busy, o_rd_en, o_sync_err});
    else passed++;
  endtask

  task automatic test_basic();
    int lat, it, held; bit bok, conv, pb;
    run_job(4, 2, 1'b0, 0, 0, lat, bok, it, conv, pb, held);
    total++; if (lat < 0) $display("FAIL basic_timeout: got no done want done"); else passed++;
    total++; if (trace_errs(4, 8) !== 0)
      $display("FAIL basic_trace: got %0d errors want 0", trace_errs(4, 8)); else passed++;
    total++; if (cnu_bad !== 0) $display("FAIL basic_cnu_valid: got %0d bad want 0", cnu_bad); else passed++;
    total++; if (it !== 2) $display("FAIL basic_iter: got %0d want 2", it); else passed++;
    total++; if (conv !== 1'b0) $display("FAIL basic_conv: got %0b want 0", conv); else passed++;
    total++; if (bok !== 1'b1) $display("FAIL basic_busy: got %0b want 1", bok); else passed++;
    total++; if (pb !== 1'b0) $display("FAIL basic_start_in_done: got busy %0b want 0", pb); else passed++;
    total++; if (held !== 2) $display("FAIL basic_iter_hold: got %0d want 2", held); else passed++;
  endtask

  task automatic test_early_stop();
    int lat, it, held; bit bok, conv, pb;
    run_job(3, 8, 1'b1, 0, 0, lat, bok, it, conv, pb, held);
    total++; if (trace_errs(3, 3) !== 0)
      $display("FAIL es_trace: got %0d errors want 0", trace_errs(3, 3)); else passed++;
    total++; if (it !== 1) $display("FAIL es_iter: got %0d want 1", it); else passed++;
    total++; if (conv !== 1'b1) $display("FAIL es_conv: got %0b want 1", conv); else passed++;
  endtask

  task automatic test_degenerate();
    int lat, it, held; bit bok, conv, pb;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) run_job(0, 5, 1'b0, 0, 0, lat, bok, it, conv, pb, held);
      else        run_job(5, 0, 1'b0, 0, 0, lat, bok, it, conv, pb, held);
      total++; if (lat !== 2) $display("FAIL degen%0d_latency: got %0d want 2", c, lat); else passed++;
      total++; if (rd_addr_q.size() !== 0)
        $display("FAIL degen%0d_reads: got %0d want 0", c, rd_addr_q.size()); else passed++;
      total++; if (it !== 0 || conv !== 1'b0)
        $display("FAIL degen%0d_result: got iter %0d conv %0b want 0 0", c, it, conv); else passed++;
    end
  endtask

  task automatic test_abort();
    int lat, it, held; bit bok, conv, pb;
    // Abort on the third ISSUE cycle, with a stray start while busy.
    run_job(8, 3, 1'b0, 3, 5, lat, bok, it, conv, pb, held);
    total++; if (trace_errs(8, 2) !== 0)
      $display("FAIL abort_issue_trace: got %0d errors want 0", trace_errs(8, 2)); else passed++;
    total++; if (it !== 0 || conv !== 1'b0)
      $display("FAIL abort_issue_result: got iter %0d conv %0b want 0 0", it, conv); else passed++;
    total++; if (lat < 0) $display("FAIL abort_issue_timeout: got no done want done"); else passed++;
    // Abort during drain of the first pass: pass completes, no CHECK.
    run_job(4, 3, 1'b0, 6, 0, lat, bok, it, conv, pb, held);
    total++; if (trace_errs(4, 4) !== 0)
      $display("FAIL abort_drain_trace: got %0d errors want 0", trace_errs(4, 4)); else passed++;
    total++; if (it !== 0 || conv !== 1'b0)
      $display("FAIL abort_drain_result: got iter %0d conv %0b want 0 0", it, conv); else passed++;
  endtask

  task automatic test_random();
    int lat, it, held, rows, iters, passes, bad; bit bok, conv, pb, es;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      rows   = $urandom_range(1, 7);
      iters  = $urandom_range(1, 3);
      es     = ($urandom_range(0, 3) == 0);
      passes = es ? 1 : iters;
      run_job(rows, iters, es, 0, 0, lat, bok, it, conv, pb, held);
      total++;
      if (trace_errs(rows, rows * passes) !== 0 || it !== passes || conv !== es || cnu_bad !== 0)
        $display("FAIL random%0d: got errs %0d iter %0d conv %0b want errs 0 iter %0d conv %0b (rows %0d)",
                 n, trace_errs(rows, rows * passes), it, conv, passes, es, rows);
      else passed++;
    end
    total++; if (o_sync_err !== 1'b0) $display("FAIL random_sync: got %0b want 0", o_sync_err); else passed++;
  endtask

  task automatic test_reset_mid_issue();
    int lat, it, held; bit bok, conv, pb;
    i_num_rows = ROW_W'(8); i_max_iter = ITER_W'(2); i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    do_reset();
    total++;
    if ({o_rd_en, o_rd_addr, o_cnu_valid, o_wr_en, o_wr_addr, o_busy, o_done,
         o_converged, o_iter_count, o_sync_err} !== '0)
      $display("FAIL midreset_outputs: got rd=%0b addr=%0d busy=%0b want all 0",
               o_rd_en, o_rd_addr, o_busy);
    else passed++;
    run_job(4, 1, 1'b0, 0, 0, lat, bok, it, conv, pb, held);
    total++; if (trace_errs(4, 4) !== 0 || it !== 1)
      $display("FAIL midreset_rerun: got errs %0d iter %0d want 0 1", trace_errs(4, 4), it); else passed++;
    total++; if (o_sync_err !== 1'b0)
      $display("FAIL midreset_mask: got sync %0b want 0", o_sync_err); else passed++;
  endtask

  task automatic test_sync_err();
    do_reset();
    repeat (2) tick();
    glitch = 1'b1; tick(); glitch = 1'b0;
    repeat (3) tick();
    total++; if (o_sync_err !== 1'b0)
      $display("FAIL sync_masked: got %0b want 0", o_sync_err); else passed++;
    repeat (20) tick();
    glitch = 1'b1; tick(); glitch = 1'b0;
    repeat (2) tick();
    total++; if (o_sync_err !== 1'b1)
      $display("FAIL sync_set: got %0b want 1", o_sync_err); else passed++;
    repeat (10) tick();
    total++; if (o_sync_err !== 1'b1)
      $display("FAIL sync_sticky: got %0b want 1", o_sync_err); else passed++;
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_early_stop();
    test_degenerate();
    test_abort();
    test_random();
    test_reset_mid_issue();
    test_sync_err();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
